// File: rtl/park_occupancy_ctrl.sv
// Parking-lot occupancy controller: per-lane two-beam direction FSMs feed a clamped occupancy counter.
// Optional macro PARK_DEBOUNCE_EN adds a 3-sample stability filter after each lane's sample stage.

module park_lane (
  input  logic       CLK,
  input  logic       reset,
  input  logic       a,
  input  logic       b,
  output logic [2:0] state,
  output logic       entry_evt,
  output logic       exit_evt,
  output logic       entry_pulse,
  output logic       exit_pulse
);
  typedef enum logic [2:0] {
    IDLE   = 3'b000, IN_A  = 3'b001, IN_AB = 3'b010, IN_B = 3'b011,
    OUT_B  = 3'b100, OUT_AB = 3'b101, OUT_A = 3'b110, BAD  = 3'b111
  } st_t;

  st_t        st, nxt;
  logic [1:0] samp, ab;

  always_ff @(posedge CLK) begin
    if (reset) samp <= 2'b00;
    else       samp <= {a, b};
  end

`ifdef PARK_DEBOUNCE_EN
  // Filter output moves only once three consecutive samples agree.
  logic [1:0] h0, h1, filt;
  always_ff @(posedge CLK) begin
    if (reset) begin
      h0   <= 2'b00;
      h1   <= 2'b00;
      filt <= 2'b00;
    end else begin
      h0 <= samp;
      h1 <= h0;
      if (samp == h0 && h0 == h1) filt <= samp;
    end
  end
  assign ab = filt;
`else
  assign ab = samp;
`endif

  always_comb begin
    nxt       = IDLE;
    entry_evt = 1'b0;
    exit_evt  = 1'b0;
    case (st)
      IDLE: case (ab)
        2'b10:   nxt = IN_A;
        2'b01:   nxt = OUT_B;
        default: nxt = IDLE;
      endcase
      IN_A: case (ab)
        2'b10:   nxt = IN_A;
        2'b11:   nxt = IN_AB;
        default: nxt = IDLE;
      endcase
      IN_AB: case (ab)
        2'b11:   nxt = IN_AB;
        2'b10:   nxt = IN_A;
        2'b01:   nxt = IN_B;
        default: nxt = IDLE;
      endcase
      IN_B: case (ab)
        2'b01:   nxt = IN_B;
        2'b11:   nxt = IN_AB;
        2'b00: begin
          nxt       = IDLE;
          entry_evt = 1'b1;
        end
        default: nxt = IDLE;
      endcase
      OUT_B: case (ab)
        2'b01:   nxt = OUT_B;
        2'b11:   nxt = OUT_AB;
        default: nxt = IDLE;
      endcase
      OUT_AB: case (ab)
        2'b11:   nxt = OUT_AB;
        2'b01:   nxt = OUT_B;
        2'b10:   nxt = OUT_A;
        default: nxt = IDLE;
      endcase
      OUT_A: case (ab)
        2'b10:   nxt = OUT_A;
        2'b11:   nxt = OUT_AB;
        2'b00: begin
          nxt      = IDLE;
          exit_evt = 1'b1;
        end
        default: nxt = IDLE;
      endcase
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      st          <= IDLE;
      entry_pulse <= 1'b0;
      exit_pulse  <= 1'b0;
    end else begin
      st          <= nxt;
      entry_pulse <= entry_evt;
      exit_pulse  <= exit_evt;
    end
  end

  assign state = st;
endmodule

module park_occupancy_ctrl #(
  parameter int LANES = 2,
  parameter int CAP   = 100,
  parameter int CW    = 8
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic [LANES-1:0]   A,
  input  logic [LANES-1:0]   B,
  input  logic               clr_err,
  output logic [CW-1:0]      occupancy,
  output logic               full,
  output logic               empty,
  output logic [LANES-1:0]   entry_pulse,
  output logic [LANES-1:0]   exit_pulse,
  output logic [3*LANES-1:0] lane_state,
  output logic               ovf_err,
  output logic               unf_err
);
  localparam logic signed [CW+3:0] CAP_S = (CW+4)'(CAP);

  logic [LANES-1:0]      ent, ext;
  logic [3:0]            n_en, n_ex;
  logic signed [CW+3:0]  sum;
  logic                  over, under;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    park_lane u_lane (
      .CLK         (CLK),
      .reset       (reset),
      .a           (A[i]),
      .b           (B[i]),
      .state       (lane_state[3*i +: 3]),
      .entry_evt   (ent[i]),
      .exit_evt    (ext[i]),
      .entry_pulse (entry_pulse[i]),
      .exit_pulse  (exit_pulse[i])
    );
  end

  always_comb begin
    n_en = '0;
    n_ex = '0;
    for (int i = 0; i < LANES; i++) begin
      n_en = n_en + 4'(ent[i]);
      n_ex = n_ex + 4'(ext[i]);
    end
  end

  // Wide signed sum so the clamp sees the true result, never a wrapped one.
  assign sum   = $signed({4'b0000, occupancy})
               + $signed({{CW{1'b0}}, n_en})
               - $signed({{CW{1'b0}}, n_ex});
  assign over  = (sum > CAP_S);
  assign under = (sum < 0);

  always_ff @(posedge CLK) begin
    if (reset) begin
      occupancy <= '0;
      ovf_err   <= 1'b0;
      unf_err   <= 1'b0;
    end else begin
      if (over)       occupancy <= CW'(CAP);
      else if (under) occupancy <= '0;
      else            occupancy <= sum[CW-1:0];
      ovf_err <= over  | (ovf_err & ~clr_err);
      unf_err <= under | (unf_err & ~clr_err);
    end
  end

  assign full  = (occupancy == CW'(CAP));
  assign empty = (occupancy == '0);
endmodule

// File: tb/tb_park_occupancy_ctrl.sv
// Directed bench for park_occupancy_ctrl: a lane-0 vector table plus hand sequences for
// clamping, error flags, simultaneous events and reset mid-passage (CAP=100 and CAP=3 instances).

module tb_park_occupancy_ctrl;
  logic       CLK = 1'b0;
  logic       reset;
  logic [1:0] A, B;
  logic       clr_err;

  logic [7:0] occupancy, s_occupancy;
  logic       full, empty, s_full, s_empty;
  logic [1:0] entry_pulse, exit_pulse, s_entry_pulse, s_exit_pulse;
  logic [5:0] lane_state, s_lane_state;
  logic       ovf_err, unf_err, s_ovf_err, s_unf_err;

  park_occupancy_ctrl #(.LANES(2), .CAP(100), .CW(8)) dut (
    .CLK(CLK), .reset(reset), .A(A), .B(B), .clr_err(clr_err),
    .occupancy(occupancy), .full(full), .empty(empty),
    .entry_pulse(entry_pulse), .exit_pulse(exit_pulse), .lane_state(lane_state),
    .ovf_err(ovf_err), .unf_err(unf_err)
  );

  park_occupancy_ctrl #(.LANES(2), .CAP(3), .CW(8)) sdut (
    .CLK(CLK), .reset(reset), .A(A), .B(B), .clr_err(clr_err),
    .occupancy(s_occupancy), .full(s_full), .empty(s_empty),
    .entry_pulse(s_entry_pulse), .exit_pulse(s_exit_pulse), .lane_state(s_lane_state),
    .ovf_err(s_ovf_err), .unf_err(s_unf_err)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0] ab;   // raw lane-0 {A,B} applied this row
    logic [2:0] st;   // lane-0 state after the row's edge
    logic       en;
    logic       ex;
    logic [7:0] occ;
    logic       unf;
  } vec_t;

  vec_t tbl [31];
  int   n_cmp = 0, n_fail = 0;
  int   en0, en1, ex0, ex1, s_en1, both_seen;
  logic s_ovf_evt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic clr_cnt();
    en0 = 0; en1 = 0; ex0 = 0; ex1 = 0; s_en1 = 0; both_seen = 0; s_ovf_evt = 1'b0;
  endtask

  // Called at a falling edge: apply inputs, advance one cycle, tally pulses.
  task automatic cyc(input logic [1:0] a, input logic [1:0] b);
    A = a; B = b;
    @(posedge CLK); @(negedge CLK);
    en0 += int'(entry_pulse[0]); en1 += int'(entry_pulse[1]);
    ex0 += int'(exit_pulse[0]);  ex1 += int'(exit_pulse[1]);
    if (entry_pulse == 2'b01 && exit_pulse == 2'b10) both_seen++;
    if (s_entry_pulse[1]) begin
      s_en1++;
      s_ovf_evt = s_ovf_err;
    end
  endtask

  // Full passage on one lane, each pair held two cycles, then two idle cycles.
  task automatic pass(input int lane, input bit ent);
    logic [1:0] sq [4];
    if (ent) sq = '{2'b10, 2'b11, 2'b01, 2'b00};
    else     sq = '{2'b01, 2'b11, 2'b10, 2'b00};
    for (int k = 0; k < 4; k++)
      repeat (2) cyc(2'({1'b0, sq[k][1]} << lane), 2'({1'b0, sq[k][0]} << lane));
    repeat (2) cyc(2'b00, 2'b00);
  endtask

  // Lane 0 enters while lane 1 exits, in lockstep.
  task automatic both_pass();
    logic [1:0] en_sq [4];
    logic [1:0] ex_sq [4];
    en_sq = '{2'b10, 2'b11, 2'b01, 2'b00};
    ex_sq = '{2'b01, 2'b11, 2'b10, 2'b00};
    for (int k = 0; k < 4; k++)
      repeat (2) cyc({ex_sq[k][1], en_sq[k][1]}, {ex_sq[k][0], en_sq[k][0]});
    repeat (2) cyc(2'b00, 2'b00);
  endtask

  initial begin
    //          ab     st      en    ex    occ   unf
    tbl[0]  = '{2'b10, 3'b000, 1'b0, 1'b0, 8'd0, 1'b0};
    tbl[1]  = '{2'b10, 3'b001, 1'b0, 1'b0, 8'd0, 1'b0};
    tbl[2]  = '{2'b11, 3'b001, 1'b0, 1'b0, 8'd0, 1'b0};
    tbl[3]  = '{2'b11, 3'b010, 1'b0, 1'b0, 8'd0, 1'b0};
    tbl[4]  = '{2'b01, 3'b010, 1'b0, 1'b0, 8'd0, 1'b0};
    tbl[5]  = '{2'b01, 3'b011, 1'b0, 1'b0, 8'd0, 1'b0};
    tbl[6]  = '{2'b00, 3'b011, 1'b0, 1'b0, 8'd0, 1'b0};
    tbl[7]  = '{2'b00, 3'b000, 1'b1, 1'b0, 8'd1, 1'b0};
    tbl[8]  = '{2'b00, 3'b000, 1'b0, 1'b0, 8'd1, 1'b0};
    tbl[9]  = '{2'b10, 3'b000, 1'b0, 1'b0, 8'd1, 1'b0};
    tbl[10] = '{2'b00, 3'b001, 1'b0, 1'b0, 8'd1, 1'b0};
    tbl[11] = '{2'b01, 3'b000, 1'b0, 1'b0, 8'd1, 1'b0};
    tbl[12] = '{2'b11, 3'b100, 1'b0, 1'b0, 8'd1, 1'b0};
    tbl[13] = '{2'b00, 3'b101, 1'b0, 1'b0, 8'd1, 1'b0};
    tbl[14] = '{2'b00, 3'b000, 1'b0, 1'b0, 8'd1, 1'b0};
    tbl[15] = '{2'b01, 3'b000, 1'b0, 1'b0, 8'd1, 1'b0};
    tbl[16] = '{2'b11, 3'b100, 1'b0, 1'b0, 8'd1, 1'b0};
    tbl[17] = '{2'b10, 3'b101, 1'b0, 1'b0, 8'd1, 1'b0};
    tbl[18] = '{2'b00, 3'b110, 1'b0, 1'b0, 8'd1, 1'b0};
    tbl[19] = '{2'b00, 3'b000, 1'b0, 1'b1, 8'd0, 1'b0};
    tbl[20] = '{2'b01, 3'b000, 1'b0, 1'b0, 8'd0, 1'b0};
    tbl[21] = '{2'b11, 3'b100, 1'b0, 1'b0, 8'd0, 1'b0};
    tbl[22] = '{2'b10, 3'b101, 1'b0, 1'b0, 8'd0, 1'b0};
    tbl[23] = '{2'b00, 3'b110, 1'b0, 1'b0, 8'd0, 1'b0};
    tbl[24] = '{2'b00, 3'b000, 1'b0, 1'b1, 8'd0, 1'b1};
    tbl[25] = '{2'b10, 3'b000, 1'b0, 1'b0, 8'd0, 1'b1};
    tbl[26] = '{2'b11, 3'b001, 1'b0, 1'b0, 8'd0, 1'b1};
    tbl[27] = '{2'b01, 3'b010, 1'b0, 1'b0, 8'd0, 1'b1};
    tbl[28] = '{2'b10, 3'b011, 1'b0, 1'b0, 8'd0, 1'b1};
    tbl[29] = '{2'b00, 3'b000, 1'b0, 1'b0, 8'd0, 1'b1};
    tbl[30] = '{2'b00, 3'b000, 1'b0, 1'b0, 8'd0, 1'b1};

    reset = 1'b1; A = 2'b00; B = 2'b00; clr_err = 1'b0;
    clr_cnt();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst occ",   32'(occupancy),   0);
    chk("rst empty", 32'(empty),       1);
    chk("rst full",  32'(full),        0);
    chk("rst state", 32'(lane_state),  0);
    chk("rst pulse", 32'({entry_pulse, exit_pulse}), 0);
    chk("rst errs",  32'({ovf_err, unf_err}), 0);
    reset = 1'b0;

    // Entry, pedestrian, abort, exits, underflow, IN_B back-out on lane 0.
    for (int i = 0; i < 31; i++) begin
      A = {1'b0, tbl[i].ab[1]};
      B = {1'b0, tbl[i].ab[0]};
      @(posedge CLK); @(negedge CLK);
      chk($sformatf("row%0d state", i), 32'(lane_state),  32'({3'b000, tbl[i].st}));
      chk($sformatf("row%0d entry", i), 32'(entry_pulse), 32'({1'b0, tbl[i].en}));
      chk($sformatf("row%0d exit", i),  32'(exit_pulse),  32'({1'b0, tbl[i].ex}));
      chk($sformatf("row%0d occ", i),   32'(occupancy),   32'(tbl[i].occ));
      chk($sformatf("row%0d empty", i), 32'(empty),       32'(tbl[i].occ == 8'd0));
      chk($sformatf("row%0d errs", i),  32'({ovf_err, unf_err}), 32'({1'b0, tbl[i].unf}));
    end

    // Sticky underflow cleared by clr_err on both instances.
    chk("unf sticky", 32'(unf_err), 1);
    clr_err = 1'b1; cyc(2'b00, 2'b00); clr_err = 1'b0;
    chk("unf clr",   32'(unf_err),   0);
    chk("s unf clr", 32'(s_unf_err), 0);

    // Three lane-1 entries fill the CAP=3 lot exactly.
    clr_cnt();
    repeat (3) pass(1, 1'b1);
    chk("occ 3",       32'(occupancy),   3);
    chk("s occ 3",     32'(s_occupancy), 3);
    chk("s full",      32'(s_full),      1);
    chk("s no ovf",    32'(s_ovf_err),   0);
    chk("en1 count",   32'(en1),         3);
    chk("en0 count",   32'(en0),         0);

    // Overflow while clr_err is held: the new error must win on its edge.
    clr_cnt();
    clr_err = 1'b1;
    pass(1, 1'b1);
    clr_err = 1'b0;
    chk("s pulse on ovf",  32'(s_en1),     1);
    chk("s ovf vs clr",    32'(s_ovf_evt), 1);
    chk("s ovf cleared",   32'(s_ovf_err), 0);
    chk("s occ clamp",     32'(s_occupancy), 3);
    chk("occ 4",           32'(occupancy),   4);

    // Overflow held until clr_err.
    pass(1, 1'b1);
    repeat (3) cyc(2'b00, 2'b00);
    chk("s ovf held",  32'(s_ovf_err),   1);
    chk("s full held", 32'(s_full),      1);
    chk("occ 5",       32'(occupancy),   5);
    clr_err = 1'b1; cyc(2'b00, 2'b00); clr_err = 1'b0;
    chk("s ovf clr",   32'(s_ovf_err),   0);

    // Lane-0 entry and lane-1 exit on the same edge cancel out.
    clr_cnt();
    both_pass();
    chk("both same cyc", 32'(both_seen),   1);
    chk("both en0",      32'(en0),         1);
    chk("both ex1",      32'(ex1),         1);
    chk("both occ",      32'(occupancy),   5);
    chk("both s occ",    32'(s_occupancy), 3);
    chk("both s ovf",    32'(s_ovf_err),   0);
    chk("both errs",     32'({ovf_err, unf_err}), 0);

    // Reset while lane 0 sits in IN_AB aborts the passage.
    clr_cnt();
    repeat (2) cyc(2'b01, 2'b00);
    repeat (2) cyc(2'b01, 2'b01);
    chk("mid IN_AB", 32'(lane_state), 32'b010);
    reset = 1'b1;
    cyc(2'b01, 2'b01);
    reset = 1'b0;
    chk("rst2 state", 32'(lane_state),  0);
    chk("rst2 occ",   32'(occupancy),   0);
    chk("rst2 empty", 32'(empty),       1);
    chk("rst2 pulse", 32'({entry_pulse, exit_pulse}), 0);
    repeat (3) cyc(2'b00, 2'b00);
    chk("rst2 no evt", 32'(en0 + en1 + ex0 + ex1), 0);
    chk("rst2 occ hold", 32'(occupancy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
